// File: rtl/sram_write_checker.sv
// SRAM write scoreboard: data compare against expected image, coverage bitmap, dup/out-of-region counts.
// Optional first-mismatch capture is built only when SRAM_CHECK_FIRST_ERR_EN is defined.
module sram_write_checker #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int REGION_LO = 146944,
  parameter int REGION_HI = 262143,
  parameter int EXP_LAT   = 1,
  parameter int CNT_W     = 32
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              SRAM_we_n,
  input  logic [ADDR_W-1:0] SRAM_address,
  input  logic [DATA_W-1:0] SRAM_write_data,
  output logic [ADDR_W-1:0] exp_address,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              check_start,
  input  logic              check_done,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  dup_count,
  output logic [CNT_W-1:0]  oor_count,
  output logic [CNT_W-1:0]  unwritten_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_address
);

  localparam int N     = REGION_HI - REGION_LO + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [ADDR_W:0]   LO_X     = (ADDR_W+1)'(REGION_LO);
  localparam logic [ADDR_W:0]   HI_X     = (ADDR_W+1)'(REGION_HI);
  localparam logic [ADDR_W-1:0] LO_A     = ADDR_W'(REGION_LO);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W:0]    SW_END   = (IDX_W+1)'(N);
  localparam logic [2:0]        DRN_LAST = 3'(EXP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MONITOR,
    S_DRAIN,
    S_SWEEP,
    S_REPORT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_idx;
  logic [2:0]       drn_cnt;
  logic [IDX_W:0]   sw_idx;
  logic             sw_vld;

  logic             wr_evt;
  logic             in_reg;
  logic [ADDR_W:0]  addr_x;
  logic [IDX_W-1:0] ev_idx;

  logic             bm [N];
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_bit;

  logic             s1_vld;
  logic [IDX_W-1:0] s1_idx;
  logic             s2_vld;
  logic [IDX_W-1:0] s2_idx;
  logic             is_dup;

  logic              pv [EXP_LAT];
  logic [DATA_W-1:0] pd [EXP_LAT];
  logic              cmp_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign exp_address = SRAM_address;

  assign addr_x = {1'b0, SRAM_address};
  assign in_reg = (addr_x >= LO_X) && (addr_x <= HI_X);
  assign wr_evt = (state == S_MONITOR) && !SRAM_we_n;
  assign ev_idx = IDX_W'(SRAM_address - LO_A);

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      clr_idx      <= '0;
      drn_cnt      <= '0;
      sw_idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (check_start) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_idx == IDX_LAST) begin
            state <= S_MONITOR;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        S_MONITOR: begin
          if (check_start) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
          end else if (check_done) begin
            state   <= S_DRAIN;
            busy    <= 1'b1;
            drn_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drn_cnt == DRN_LAST) begin
            state  <= S_SWEEP;
            sw_idx <= '0;
          end else begin
            drn_cnt <= drn_cnt + 3'd1;
          end
        end
        S_SWEEP: begin
          // one extra cycle after the last issue lets the final bitmap read be counted
          if (sw_idx == SW_END) begin
            state        <= S_REPORT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            sw_idx <= sw_idx + (IDX_W+1)'(1);
          end
        end
        S_REPORT: begin
          if (check_start) begin
            state        <= S_CLEAR;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            clr_idx      <= '0;
          end
        end
        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  // Single read port shared by the monitor lookup and the coverage sweep.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = ev_idx;
    if (state == S_SWEEP) begin
      rd_en  = (sw_idx != SW_END);
      rd_idx = sw_idx[IDX_W-1:0];
    end else if (wr_evt && in_reg) begin
      rd_en = 1'b1;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (state == S_CLEAR) begin
      bm[clr_idx] <= 1'b0;
    end else if (s1_vld) begin
      bm[s1_idx] <= 1'b1;
    end
    if (rd_en) begin
      rd_bit <= bm[rd_idx];
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset || state == S_CLEAR) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_idx <= '0;
      s2_idx <= '0;
      sw_vld <= 1'b0;
    end else begin
      s1_vld <= wr_evt && in_reg;
      s1_idx <= ev_idx;
      s2_vld <= s1_vld;
      s2_idx <= s1_idx;
      sw_vld <= (state == S_SWEEP) && (sw_idx != SW_END);
    end
  end

  // The previous write's bit is set on the same edge this write reads, so forward it.
  assign is_dup = s1_vld && (rd_bit || (s2_vld && (s2_idx == s1_idx)));

  always_ff @(posedge Clock_50) begin
    if (Reset || state == S_CLEAR) begin
      for (int k = 0; k < EXP_LAT; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= wr_evt && in_reg;
      for (int k = 1; k < EXP_LAT; k++) pv[k] <= pv[k-1];
    end
  end

  always_ff @(posedge Clock_50) begin
    pd[0] <= SRAM_write_data;
    for (int k = 1; k < EXP_LAT; k++) pd[k] <= pd[k-1];
  end

  assign cmp_bad = pv[EXP_LAT-1] && (pd[EXP_LAT-1] != exp_data);

  always_ff @(posedge Clock_50) begin
    if (Reset || state == S_CLEAR) begin
      mismatch_count  <= '0;
      dup_count       <= '0;
      oor_count       <= '0;
      unwritten_count <= '0;
    end else begin
      if (wr_evt && !in_reg) oor_count <= sat_inc(oor_count);
      if (is_dup) dup_count <= sat_inc(dup_count);
      if (cmp_bad) mismatch_count <= sat_inc(mismatch_count);
      if (sw_vld && !rd_bit) unwritten_count <= sat_inc(unwritten_count);
    end
  end

`ifdef SRAM_CHECK_FIRST_ERR_EN
  logic [ADDR_W-1:0] pa [EXP_LAT];

  always_ff @(posedge Clock_50) begin
    pa[0] <= SRAM_address;
    for (int k = 1; k < EXP_LAT; k++) pa[k] <= pa[k-1];
  end

  always_ff @(posedge Clock_50) begin
    if (Reset || state == S_CLEAR) begin
      first_err_valid   <= 1'b0;
      first_err_address <= '0;
    end else if (cmp_bad && !first_err_valid) begin
      first_err_valid   <= 1'b1;
      first_err_address <= pa[EXP_LAT-1];
    end
  end
`else
  assign first_err_valid   = 1'b0;
  assign first_err_address = '0;
`endif

endmodule

// File: tb/tb_sram_write_checker.sv
// Directed bench for sram_write_checker: region 100..107, 3-cycle expected memory, 4-bit counters.
module tb_sram_write_checker;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int LO  = 100;
  localparam int HI  = 107;
  localparam int LAT = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdat;
  logic [AW-1:0] exp_address;
  logic [DW-1:0] exp_data;
  logic          check_start;
  logic          check_done;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] mismatch_count;
  logic [CW-1:0] dup_count;
  logic [CW-1:0] oor_count;
  logic [CW-1:0] unwritten_count;
  logic          first_err_valid;
  logic [AW-1:0] first_err_address;

  always #5 clk = ~clk;

  sram_write_checker #(
    .ADDR_W(AW), .DATA_W(DW), .REGION_LO(LO), .REGION_HI(HI), .EXP_LAT(LAT), .CNT_W(CW)
  ) dut (
    .Clock_50(clk),
    .Reset(rst),
    .SRAM_we_n(we_n),
    .SRAM_address(addr),
    .SRAM_write_data(wdat),
    .exp_address(exp_address),
    .exp_data(exp_data),
    .check_start(check_start),
    .check_done(check_done),
    .busy(busy),
    .result_valid(result_valid),
    .mismatch_count(mismatch_count),
    .dup_count(dup_count),
    .oor_count(oor_count),
    .unwritten_count(unwritten_count),
    .first_err_valid(first_err_valid),
    .first_err_address(first_err_address)
  );

  function automatic logic [DW-1:0] exp_fn(input logic [AW-1:0] a);
    if (a == AW'(104)) return 16'hBEEE;
    return (a[15:0] * 16'h0101) ^ 16'h3C3C;
  endfunction

  // Expected-image memory with LAT cycles of read latency.
  logic [DW-1:0] d1, d2, d3;
  always @(posedge clk) begin
    d1 <= exp_fn(exp_address);
    d2 <= d1;
    d3 <= d2;
  end
  assign exp_data = d3;

  typedef struct {
    logic [7:0] mask;
    int         dup_a;
    int         n_oor;
    logic       bad;
    int         e_mis;
    int         e_dup;
    int         e_oor;
    int         e_unw;
  } vec_t;

  vec_t vecs [7];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    we_n = 1'b0;
    addr = AW'(a);
    wdat = d;
    @(negedge clk);
  endtask

  task automatic start_run(input string nm);
    int n = 0;
    check_start = 1'b1;
    @(negedge clk);
    check_start = 1'b0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_clear_done"}, int'(busy), 0);
  endtask

  task automatic finish_run(input string nm);
    int n = 0;
    check_done = 1'b1;
    @(negedge clk);
    check_done = 1'b0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_report"}, int'(result_valid), 1);
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string nm;
    int    a;
    int    fev;
    v  = vecs[i];
    nm = $sformatf("v%0d", i);
    start_run(nm);
    for (int k = 0; k < 8; k++) begin
      if (v.mask[k]) begin
        a = LO + k;
        wr(a, (v.bad && a == 104) ? 16'hBEEF : exp_fn(AW'(a)));
        if (a == v.dup_a) wr(a, (v.bad && a == 104) ? 16'hBEEF : exp_fn(AW'(a)));
      end
    end
    for (int k = 0; k < v.n_oor; k++) wr((k % 2 == 1) ? HI + 1 : LO - 1, 16'h1234);
    we_n = 1'b1;
    finish_run(nm);
    chk({nm, "_mismatch"}, int'(mismatch_count), v.e_mis);
    chk({nm, "_dup"}, int'(dup_count), v.e_dup);
    chk({nm, "_oor"}, int'(oor_count), v.e_oor);
    chk({nm, "_unwritten"}, int'(unwritten_count), v.e_unw);
    chk({nm, "_busy"}, int'(busy), 0);
`ifdef SRAM_CHECK_FIRST_ERR_EN
    fev = (v.e_mis > 0) ? 1 : 0;
`else
    fev = 0;
`endif
    chk({nm, "_ferr_valid"}, int'(first_err_valid), fev);
    chk({nm, "_ferr_addr"}, int'(first_err_address), (fev == 1) ? 104 : 0);
  endtask

  initial begin
    vecs[0] = '{8'hFF, -1,  0, 1'b0, 0, 0,  0, 0};
    vecs[1] = '{8'h3F, -1,  0, 1'b0, 0, 0,  0, 2};
    vecs[2] = '{8'hFF, 103, 2, 1'b0, 0, 1,  2, 0};
    vecs[3] = '{8'h10, -1,  0, 1'b1, 1, 0,  0, 7};
    vecs[4] = '{8'h00, -1, 20, 1'b0, 0, 0, 15, 8};
    vecs[5] = '{8'hAA, 107, 0, 1'b0, 0, 1,  0, 4};
    vecs[6] = '{8'hFF, 104, 0, 1'b1, 2, 1,  0, 0};

    rst = 1'b1;
    we_n = 1'b1;
    addr = '0;
    wdat = '0;
    check_start = 1'b0;
    check_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_mismatch", int'(mismatch_count), 0);
    chk("rst_dup", int'(dup_count), 0);
    chk("rst_oor", int'(oor_count), 0);
    chk("rst_unwritten", int'(unwritten_count), 0);
    chk("rst_ferr_valid", int'(first_err_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // Writes in idle are ignored.
    wr(99, 16'h0);
    we_n = 1'b1;
    @(negedge clk);
    chk("idle_write_ignored", int'(oor_count), 0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // In report: check_done and writes are ignored, results held.
    check_done = 1'b1;
    wr(99, 16'h0);
    wr(LO, 16'h0);
    check_done = 1'b0;
    we_n = 1'b1;
    @(negedge clk);
    chk("report_hold_valid", int'(result_valid), 1);
    chk("report_hold_mis", int'(mismatch_count), 2);
    chk("report_hold_oor", int'(oor_count), 0);
    chk("report_hold_dup", int'(dup_count), 1);

    // check_start and check_done together in monitor: restart wins.
    start_run("tie");
    wr(LO - 1, 16'h0);
    wr(HI + 1, 16'h0);
    wr(LO, exp_fn(AW'(LO)));
    we_n = 1'b1;
    @(negedge clk);
    chk("tie_oor_before", int'(oor_count), 2);
    check_start = 1'b1;
    check_done = 1'b1;
    @(negedge clk);
    check_start = 1'b0;
    check_done = 1'b0;
    chk("tie_busy_clear", int'(busy), 1);
    repeat (2) @(negedge clk);
    chk("tie_oor_zeroed", int'(oor_count), 0);
    start_run("tie2");
    finish_run("tie2");
    chk("tie_unwritten", int'(unwritten_count), 8);
    chk("tie_oor_after", int'(oor_count), 0);

    // Reset three cycles into the sweep.
    start_run("swrst");
    wr(LO, exp_fn(AW'(LO)));
    wr(LO, exp_fn(AW'(LO)));
    wr(104, 16'hBEEF);
    wr(LO - 1, 16'h0);
    wr(HI + 1, 16'h0);
    we_n = 1'b1;
    check_done = 1'b1;
    @(negedge clk);
    check_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("swrst_busy_in_sweep", int'(busy), 1);
    chk("swrst_oor_before", int'(oor_count), 2);
    chk("swrst_mis_before", int'(mismatch_count), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("swrst_busy", int'(busy), 0);
    chk("swrst_result_valid", int'(result_valid), 0);
    chk("swrst_mis", int'(mismatch_count), 0);
    chk("swrst_dup", int'(dup_count), 0);
    chk("swrst_oor", int'(oor_count), 0);
    chk("swrst_unwritten", int'(unwritten_count), 0);
    chk("swrst_ferr_valid", int'(first_err_valid), 0);
    repeat (12) @(negedge clk);
    chk("swrst_stays_idle", int'(result_valid), 0);
    run_vec(1);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
